exp_normalizer: RTL and testbench

- Streaming stage directly downstream of the piecewise-linear exp approximator in the QFT fixed-point datapath.
- Collects a vector of N exp values and sums them, then emits each value divided by the sum (softmax-style normalisation). Output is in the same signed fixed-point format.
- Valid/ready handshake on both sides. Division is iterative (one quotient bit per cycle), so the block is sequential and non-overlapping: load phase, then divide/output phase.

---
 rtl/exp_normalizer_pkg.sv | 22 ++
 rtl/exp_normalizer_div.sv | 71 +++++++
 rtl/exp_normalizer.sv | 152 +++++++++++++++
 tb/tb_exp_normalizer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exp_normalizer_pkg.sv
// Fixed-point format, sum-width helper and FSM encodings shared by the exp normaliser.
// The macros stand in for fixed_point_params.vh so every later file in the bundle sees them.
`ifndef FIXED_POINT_PARAMS_VH
`define FIXED_POINT_PARAMS_VH
`define TOTAL_WIDTH 8
`define FRAC_WIDTH 4
`define SUM_WIDTH(w, n) ((w) - 1 + $clog2(n))
`define EXPN_ST_LOAD 2'd0
`define EXPN_ST_DIV 2'd1
`define EXPN_ST_OUT 2'd2
`endif

package exp_normalizer_pkg;
  localparam int TOTAL_W = `TOTAL_WIDTH;
  localparam int FRAC_W = `FRAC_WIDTH;

  localparam logic [1:0] ST_LOAD = `EXPN_ST_LOAD;
  localparam logic [1:0] ST_DIV = `EXPN_ST_DIV;
  localparam logic [1:0] ST_OUT = `EXPN_ST_OUT;

  typedef logic [1:0] state_t;
endpackage

// File: rtl/exp_normalizer_div.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge.
// Denominator zero is not handled here.
module fxp_restoring_div #(
  parameter int NW = 11,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [NW-1:0] quo,
  output logic          done
);
  localparam int CNTW = $clog2(NW + 1);

  logic [DW-1:0]   rem_q, rem_d;
  logic [NW-1:0]   q_q, q_d;
  logic [DW-1:0]   den_q;
  logic [CNTW-1:0] cnt_q;
  logic            run_q;
  logic            done_q;

  logic [DW-1:0] rem_src, den_src, diff;
  logic [NW-1:0] q_src;
  logic [DW:0]   trial;
  logic          ge;

  // On start the step works directly on the incoming operands.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    q_src   = start ? num : q_q;
    den_src = start ? den : den_q;
    trial   = {rem_src, q_src[NW-1]};
    ge      = (trial >= {1'b0, den_src});
    diff    = trial[DW-1:0] - den_src;
    rem_d   = ge ? diff : trial[DW-1:0];
    q_d     = {q_src[NW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      q_q    <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= rem_d;
        q_q   <= q_d;
        den_q <= den;
        cnt_q <= CNTW'(NW - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= rem_d;
        q_q   <= q_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quo  = q_q;
  assign done = done_q;
endmodule

// File: rtl/exp_normalizer.sv
// Softmax-style normaliser: buffers N clamped exp values, sums them, then streams e_k*2^F/sum.
// Handshake: a beat transfers on a rising edge where valid && ready; valid holds its data until then.
module exp_normalizer
  import exp_normalizer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = TOTAL_W,
  parameter int F = FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_zero_sum,
  output logic         busy,
  output logic [1:0]   dbg_state
);
  localparam int SW = `SUM_WIDTH(W, N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int NW = W - 1 + F;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          start_q, start_d;
  logic          ov_q, ov_d;
  logic [W-1:0]  od_q, od_d;
  logic          ol_q, ol_d;
  logic          oz_q, oz_d;
  logic [W-2:0]  buf_q [N];

  logic [W-2:0]  in_clamped;
  logic [NW-1:0] div_num, div_quo;
  logic [W-2:0]  quo_sat;
  logic          div_done;
  logic          accept;

  assign in_ready   = (state_q == ST_LOAD);
  assign accept     = in_valid && in_ready;
  assign in_clamped = in_data[W-1] ? '0 : in_data[W-2:0];
  assign div_num    = {buf_q[idx_q], {F{1'b0}}};
  assign quo_sat    = (|div_quo[NW-1:W-1]) ? '1 : div_quo[W-2:0];

  fxp_restoring_div #(
    .NW(NW),
    .DW(SW)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_q),
    .num  (div_num),
    .den  (sum_q),
    .quo  (div_quo),
    .done (div_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    start_d = 1'b0;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    oz_d    = oz_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          sum_d = sum_q + SW'(in_clamped);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_DIV;
            cnt_d   = '0;
            idx_d   = '0;
            start_d = (sum_d != '0);
          end
        end
      end
      ST_DIV: begin
        // A zero sum bypasses the divider and emits a flagged zero beat.
        if (sum_q == '0) begin
          state_d = ST_OUT;
          ov_d    = 1'b1;
          od_d    = '0;
          ol_d    = (idx_q == CW'(N - 1));
          oz_d    = 1'b1;
        end else if (div_done) begin
          state_d = ST_OUT;
          ov_d    = 1'b1;
          od_d    = {1'b0, quo_sat};
          ol_d    = (idx_q == CW'(N - 1));
          oz_d    = 1'b0;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (idx_q == CW'(N - 1)) begin
            state_d = ST_LOAD;
            sum_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_DIV;
            idx_d   = idx_q + 1'b1;
            start_d = (sum_q != '0);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      start_q <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      oz_q    <= 1'b0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      oz_q    <= oz_d;
      if (accept) buf_q[cnt_q] <= in_clamped;
    end
  end

  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_last     = ol_q;
  assign out_zero_sum = oz_q;
  assign busy         = (state_q != ST_LOAD);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_exp_normalizer.sv
// Directed bench for exp_normalizer with N=4 in Q4.4; expected values are hand-computed.
module tb_exp_normalizer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_zero_sum;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  exp_normalizer #(.N(4), .W(8), .F(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_zero_sum(out_zero_sum),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic recv(input string tag, input logic [7:0] ed, input logic el,
                      input logic ez, input int elat, input int hold);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, ed});
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, el});
    check({tag, "_zs"}, {31'd0, out_zero_sum}, {31'd0, ez});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'd99;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_hold_data"}, {24'd0, out_data}, {24'd0, ed});
        check({tag, "_hold_last"}, {31'd0, out_last}, {31'd0, el});
        check({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_zs", {31'd0, out_zero_sum}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_inrdy", {31'd0, in_ready}, 32'd1);

    // Uniform: 16*16/64 = 4
    send_vec(8'd16, 8'd16, 8'd16, 8'd16);
    check("uni_div_state", {30'd0, dbg_state}, 32'd1);
    recv("uni0", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("uni1", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("uni2", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("uni3", 8'd4, 1'b1, 1'b0, 12, 0);
    check("uni_idle_busy", {31'd0, busy}, 32'd0);

    // One-hot: 512/32 = 16
    send_vec(8'd32, 8'd0, 8'd0, 8'd0);
    recv("hot0", 8'd16, 1'b0, 1'b0, 12, 0);
    recv("hot1", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("hot2", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("hot3", 8'd0, 1'b1, 1'b0, 12, 0);

    // Max input: 2032/128 = 15.875 -> 15, 16/128 -> 0
    send_vec(8'd127, 8'd1, 8'd0, 8'd0);
    recv("max0", 8'd15, 1'b0, 1'b0, 12, 0);
    recv("max1", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("max2", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("max3", 8'd0, 1'b1, 1'b0, 12, 0);

    // Negative clamp: -5 -> 0, sum 10, 160/10 = 16
    send_vec(8'hFB, 8'd10, 8'd0, 8'd0);
    recv("neg0", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("neg1", 8'd16, 1'b0, 1'b0, 12, 0);
    recv("neg2", 8'd0, 1'b0, 1'b0, 12, 0);
    recv("neg3", 8'd0, 1'b1, 1'b0, 12, 0);

    // Zero sum: divider bypassed, one cycle per beat
    send_vec(8'd0, 8'd0, 8'd0, 8'd0);
    recv("zero0", 8'd0, 1'b0, 1'b1, 1, 0);
    recv("zero1", 8'd0, 1'b0, 1'b1, 1, 0);
    recv("zero2", 8'd0, 1'b0, 1'b1, 1, 0);
    recv("zero3", 8'd0, 1'b1, 1'b1, 1, 0);

    // Backpressure on beat 2: sum 96 -> 256/96=2, 512/96=5, 768/96=8, 0
    send_vec(8'd16, 8'd32, 8'd48, 8'd0);
    recv("bp0", 8'd2, 1'b0, 1'b0, 12, 0);
    recv("bp1", 8'd5, 1'b0, 1'b0, 12, 5);
    recv("bp2", 8'd8, 1'b0, 1'b0, 12, 0);
    recv("bp3", 8'd0, 1'b1, 1'b0, 12, 0);

    // Reset during the second divide
    send_vec(8'd16, 8'd16, 8'd16, 8'd16);
    recv("mid0", 8'd4, 1'b0, 1'b0, 12, 0);
    repeat (4) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_inrdy", {31'd0, in_ready}, 32'd1);
    send_vec(8'd16, 8'd16, 8'd16, 8'd16);
    recv("post0", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("post1", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("post2", 8'd4, 1'b0, 1'b0, 12, 0);
    recv("post3", 8'd4, 1'b1, 1'b0, 12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
